// File: rtl/pipeline_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the decode-stage hazard controller:
//   - RegCountDefault : default number of tracked architectural registers
//   - RegIdxW         : width of a register index
//   - state_e         : controller FSM state encoding (also exported for debug)
// ----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int unsigned RegCountDefault = 32;
    localparam int unsigned RegIdxW         = 5;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StEcall = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
// Per-register count of issued-but-not-retired writes plus a "last issue was a
// load" bit. Register 0 is never tracked.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   inc_en_i/inc_idx_i      issue of a write to inc_idx_i
//   inc_is_load_i           the issuing instruction is a load
//   dec_en_i/dec_idx_i      writeback retiring a write to dec_idx_i
//   cnt_o                   per-register outstanding-write counters
//   ld_o                    per-register load bit
//   busy_o                  any counter nonzero
// ----------------------------------------------------------------------------
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_COUNT = RegCountDefault,
    parameter int unsigned CNT_W     = 2
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             inc_en_i,
    input  logic [RegIdxW-1:0]               inc_idx_i,
    input  logic                             inc_is_load_i,
    input  logic                             dec_en_i,
    input  logic [RegIdxW-1:0]               dec_idx_i,
    output logic [REG_COUNT-1:0][CNT_W-1:0]  cnt_o,
    output logic [REG_COUNT-1:0]             ld_o,
    output logic                             busy_o
);

    assign cnt_o[0] = '0;
    assign ld_o[0]  = 1'b0;

    for (genvar r = 1; r < REG_COUNT; r++) begin : g_reg
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             ld_q, ld_d;
        logic             inc, dec;

        assign inc = inc_en_i && (inc_idx_i == RegIdxW'(r));
        // A retirement against an empty counter is dropped (no underflow).
        assign dec = dec_en_i && (dec_idx_i == RegIdxW'(r)) && (cnt_q != '0);

        always_comb begin
            cnt_d = cnt_q;
            ld_d  = ld_q;
            if (inc && !dec) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (inc) begin
                ld_d = inc_is_load_i;
            end
            if (cnt_d == '0) begin
                ld_d = 1'b0;
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                cnt_q <= '0;
                ld_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                ld_q  <= ld_d;
            end
        end

        assign cnt_o[r] = cnt_q;
        assign ld_o[r]  = ld_q;
    end

    always_comb begin
        busy_o = 1'b0;
        for (int unsigned r = 0; r < REG_COUNT; r++) begin
            busy_o = busy_o | (cnt_o[r] != '0);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Decode-stage hazard and ECALL sequencing controller. Stalls decode on RAW
// hazards against outstanding writes and on counter saturation, and serialises
// ECALL: drain all outstanding writes, pulse ecall_go_o, wait for ecall_done_i.
// Config macro: HAZARD_FORWARDING_EN -- when defined, only outstanding loads
// cause RAW stalls (ALU results are assumed forwarded).
// Ports:
//   clk_i, reset_i                     clock, synchronous active-high reset
//   dec_valid_i                        decode holds a non-NOP instruction
//   dec_r1_reg_i/dec_r2_reg_i          source registers
//   dec_r1_used_i/dec_r2_used_i        source actually read
//   dec_dst_reg_i                      destination (0 = no write)
//   dec_is_load_i, dec_ecall_i         instruction kind
//   wb_valid_i, wb_dst_reg_i           writeback retiring a register write
//   ecall_done_i                       environment call handler finished
//   dec_stall_o                        hold decode
//   issue_fire_o                       instruction leaves decode this cycle
//   ecall_go_o                         one-cycle pulse, ECALL may execute
//   busy_o                             any write outstanding
//   state_o                            FSM state (debug)
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_COUNT = RegCountDefault,
    parameter int unsigned CNT_W     = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               dec_valid_i,
    input  logic [RegIdxW-1:0] dec_r1_reg_i,
    input  logic [RegIdxW-1:0] dec_r2_reg_i,
    input  logic               dec_r1_used_i,
    input  logic               dec_r2_used_i,
    input  logic [RegIdxW-1:0] dec_dst_reg_i,
    input  logic               dec_is_load_i,
    input  logic               dec_ecall_i,
    input  logic               wb_valid_i,
    input  logic [RegIdxW-1:0] wb_dst_reg_i,
    input  logic               ecall_done_i,
    output logic               dec_stall_o,
    output logic               issue_fire_o,
    output logic               ecall_go_o,
    output logic               busy_o,
    output logic [1:0]         state_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [REG_COUNT-1:0][CNT_W-1:0] cnt;
    logic                            busy;
    logic                            raw1, raw2, structural, hazard;
    state_e                          state_q;
`ifdef HAZARD_FORWARDING_EN
    logic [REG_COUNT-1:0]            ld;
`endif

    hazard_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .CNT_W     (CNT_W)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .inc_en_i      (issue_fire_o),
        .inc_idx_i     (dec_dst_reg_i),
        .inc_is_load_i (dec_is_load_i),
        .dec_en_i      (wb_valid_i),
        .dec_idx_i     (wb_dst_reg_i),
        .cnt_o         (cnt),
`ifdef HAZARD_FORWARDING_EN
        .ld_o          (ld),
`else
        .ld_o          (),
`endif
        .busy_o        (busy)
    );

    // Hazards look only at registered scoreboard state: a writeback in this
    // cycle clears the stall from the next cycle on.
    always_comb begin
        raw1 = dec_r1_used_i && (dec_r1_reg_i != '0) && (cnt[dec_r1_reg_i] != '0);
        raw2 = dec_r2_used_i && (dec_r2_reg_i != '0) && (cnt[dec_r2_reg_i] != '0);
`ifdef HAZARD_FORWARDING_EN
        raw1 = raw1 && ld[dec_r1_reg_i];
        raw2 = raw2 && ld[dec_r2_reg_i];
`endif
        structural = (dec_dst_reg_i != '0) && (cnt[dec_dst_reg_i] == CntMax);
        hazard     = raw1 || raw2 || structural;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StRun;
        end else begin
            unique case (state_q)
                StRun:   if (dec_valid_i && dec_ecall_i && !hazard) state_q <= StDrain;
                StDrain: if (!busy) state_q <= StEcall;
                StEcall: if (ecall_done_i) state_q <= StRun;
                default: state_q <= StRun;
            endcase
        end
    end

    always_comb begin
        dec_stall_o  = 1'b1;
        issue_fire_o = 1'b0;
        ecall_go_o   = 1'b0;
        if (!reset_i) begin
            unique case (state_q)
                StRun: begin
                    dec_stall_o  = dec_valid_i && (hazard || dec_ecall_i);
                    issue_fire_o = dec_valid_i && !(hazard || dec_ecall_i);
                end
                StDrain: begin
                    ecall_go_o = !busy;
                end
                StEcall: begin
                    // The held ECALL leaves decode in the cycle the handler finishes.
                    dec_stall_o  = !ecall_done_i;
                    issue_fire_o = ecall_done_i;
                end
                default: begin
                    dec_stall_o = 1'b1;
                end
            endcase
        end
    end

    assign busy_o  = busy;
    assign state_o = reset_i ? StRun : state_q;

endmodule
